// File: rtl/icache.sv
// Direct-mapped, one-word-per-line, read-only instruction cache.
// Hits are served combinationally in COMPARE; a miss latches the word address
// and runs a single-word fill from memory, holding ihit low until it completes.
// Ports:
//   CLK, nRST          clock and asynchronous active-low reset
//   imemREN, imemaddr  fetch-stage read request and byte address
//   ihit, imemload     hit flag and instruction word (0 when no hit)
//   iREN, iaddr        memory read request and word-aligned miss address
//   iwait, iload       memory busy flag and read data
module icache #(
   parameter int unsigned SETS = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
);

   localparam int unsigned IW = $clog2(SETS);
   localparam int unsigned TW = 30 - IW;

   typedef enum logic {
      COMPARE = 1'b0,
      FILL    = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [29:0]     miss_addr_q, miss_addr_d;
   logic [SETS-1:0] valid_q, valid_d;
   logic [TW-1:0]   tag_q  [SETS];
   logic [31:0]     data_q [SETS];

   logic [IW-1:0]   req_idx, miss_idx;
   logic [TW-1:0]   req_tag, miss_tag;
   logic            hit_c;
   logic            fill_we_c;
   logic [1:0]      unused_byte_offset;

   // Address split for the live request and the latched miss
   assign req_tag  = imemaddr[31:IW+2];
   assign req_idx  = imemaddr[IW+1:2];
   assign miss_tag = miss_addr_q[29:IW];
   assign miss_idx = miss_addr_q[IW-1:0];

   // Byte offset within the word plays no part in the lookup
   assign unused_byte_offset = imemaddr[1:0];

   // Lookup is only meaningful in COMPARE; during a fill the request is ignored
   assign hit_c = (state_q == COMPARE) && imemREN && valid_q[req_idx]
                  && (tag_q[req_idx] == req_tag);

   assign ihit     = hit_c;
   assign imemload = hit_c ? data_q[req_idx] : 32'h0;
   assign iREN     = (state_q == FILL);
   assign iaddr    = {miss_addr_q, 2'b00};

   // Next-state, miss latch and fill-enable
   always_comb begin
      state_d     = state_q;
      miss_addr_d = miss_addr_q;
      valid_d     = valid_q;
      fill_we_c   = 1'b0;
      case (state_q)
         COMPARE: begin
            if (imemREN && !hit_c) begin
               miss_addr_d = imemaddr[31:2];
               state_d     = FILL;
            end
         end
         FILL: begin
            if (!iwait) begin
               fill_we_c          = 1'b1;
               valid_d[miss_idx]  = 1'b1;
               state_d            = COMPARE;
            end
         end
         default: state_d = COMPARE;
      endcase
   end

   // Control state and valid bits; reset invalidates every line
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= COMPARE;
         miss_addr_q <= 30'h0;
         valid_q     <= '0;
      end else begin
         state_q     <= state_d;
         miss_addr_q <= miss_addr_d;
         valid_q     <= valid_d;
      end
   end

   // Tag/data arrays are not reset; valid bits guard them
   always_ff @(posedge CLK) begin
      if (fill_we_c) begin
         tag_q[miss_idx]  <= miss_tag;
         data_q[miss_idx] <= iload;
      end
   end

endmodule

// File: tb/tb_icache.sv
module tb_icache;

   localparam int unsigned SETS = 16;

   logic        CLK;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;

   int checks   = 0;
   int failures = 0;

   // Reference model: each line remembers which word address it holds
   bit          m_valid [SETS];
   logic [29:0] m_waddr [SETS];
   logic [31:0] m_data  [SETS];

   icache #(.SETS(SETS)) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .imemREN  (imemREN),
      .imemaddr (imemaddr),
      .ihit     (ihit),
      .imemload (imemload),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic int line_of(input logic [31:0] a);
      return int'((a >> 2) % SETS);
   endfunction

   function automatic bit model_hit(input logic [31:0] a);
      int l = line_of(a);
      return m_valid[l] && (m_waddr[l] == a[31:2]);
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
   endfunction

   function automatic void model_fill(input logic [31:0] a, input logic [31:0] d);
      int l = line_of(a);
      m_valid[l] = 1'b1;
      m_waddr[l] = a[31:2];
      m_data[l]  = d;
   endfunction

   task automatic apply_reset();
      @(negedge CLK);
      nRST = 1'b0; imemREN = 1'b0; iwait = 1'b1;
      @(negedge CLK);
      nRST = 1'b1;
      model_clear();
   endtask

   // One fetch: hit checked against the model, or a full miss/fill of latency lat
   task automatic access(input logic [31:0] a, input int lat, input logic [31:0] d);
      bit          exp_hit;
      logic [31:0] exp_data;
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = a; iwait = 1'b1; iload = $urandom;
      #1;
      exp_hit  = model_hit(a);
      exp_data = exp_hit ? m_data[line_of(a)] : 32'h0;
      checks++;
      if (ihit !== exp_hit) begin
         failures++;
         $display("FAIL access_ihit addr=%h got=%b exp=%b", a, ihit, exp_hit);
      end
      checks++;
      if (imemload !== exp_data) begin
         failures++;
         $display("FAIL access_load addr=%h got=%h exp=%h", a, imemload, exp_data);
      end
      checks++;
      if (iREN !== 1'b0) begin
         failures++;
         $display("FAIL access_iren_compare addr=%h got=%b exp=0", a, iREN);
      end
      if (!exp_hit) begin
         for (int k = 0; k <= lat; k++) begin
            @(negedge CLK);
            iwait = (k < lat);
            iload = (k == lat) ? d : $urandom;
            #1;
            checks++;
            if (iREN !== 1'b1 || iaddr !== {a[31:2], 2'b00} || ihit !== 1'b0) begin
               failures++;
               $display("FAIL fill_cycle%0d addr=%h got iREN=%b iaddr=%h ihit=%b exp 1/%h/0",
                        k, a, iREN, iaddr, ihit, {a[31:2], 2'b00});
            end
         end
         model_fill(a, d);
         @(negedge CLK);
         iwait = 1'b1; iload = $urandom;
         #1;
         checks++;
         if (ihit !== 1'b1 || imemload !== d || iREN !== 1'b0) begin
            failures++;
            $display("FAIL after_fill addr=%h got ihit=%b load=%h iREN=%b exp 1/%h/0",
                     a, ihit, imemload, iREN, d);
         end
      end
   endtask

   task automatic test_reset();
      nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;
      model_clear();
      @(negedge CLK);
      #1;
      checks++;
      if (ihit !== 1'b0 || iREN !== 1'b0 || imemload !== 32'h0 || iaddr !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs got ihit=%b iREN=%b load=%h iaddr=%h exp 0/0/0/0",
                  ihit, iREN, imemload, iaddr);
      end
      @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);
      iwait = 1'b0; iload = 32'hCAFE0000;
      #1;
      checks++;
      if (iREN !== 1'b1 || iaddr !== 32'h0) begin
         failures++;
         $display("FAIL reset_release_fill got iREN=%b iaddr=%h exp 1/00000000", iREN, iaddr);
      end
      model_fill(32'h0, 32'hCAFE0000);
      @(negedge CLK);
      iwait = 1'b1;
      #1;
      checks++;
      if (ihit !== 1'b1 || imemload !== 32'hCAFE0000) begin
         failures++;
         $display("FAIL reset_first_hit got ihit=%b load=%h exp 1/cafe0000", ihit, imemload);
      end
   endtask

   task automatic test_cold_miss();
      access(32'h0000_0010, 2, 32'h8C22_0004);
   endtask

   task automatic test_conflict();
      apply_reset();
      access(32'h0000_0000, 1, 32'h1111_1111);
      access(32'h0000_0000, 1, 32'h0BAD_0BAD);   // model expects a hit here
      access(32'h0000_0040, 1, 32'h2222_2222);
      access(32'h0000_0000, 1, 32'h3333_3333);   // evicted: miss, iaddr 0
   endtask

   task automatic test_addr_change();
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'h20; iwait = 1'b1;
      #1;
      checks++;
      if (ihit !== 1'b0) begin
         failures++;
         $display("FAIL chg_miss got ihit=%b exp 0", ihit);
      end
      @(negedge CLK);
      imemaddr = 32'h24;
      #1;
      checks++;
      if (iREN !== 1'b1 || iaddr !== 32'h20) begin
         failures++;
         $display("FAIL chg_iaddr_held got iREN=%b iaddr=%h exp 1/00000020", iREN, iaddr);
      end
      @(negedge CLK);
      iwait = 1'b0; iload = 32'h2020_2020;
      #1;
      model_fill(32'h20, 32'h2020_2020);
      @(negedge CLK);
      iwait = 1'b1; iload = $urandom;
      #1;
      checks++;
      if (ihit !== 1'b0 || iREN !== 1'b0) begin
         failures++;
         $display("FAIL chg_compare_miss got ihit=%b iREN=%b exp 0/0", ihit, iREN);
      end
      @(negedge CLK);
      iwait = 1'b0; iload = 32'h2424_2424;
      #1;
      checks++;
      if (iREN !== 1'b1 || iaddr !== 32'h24) begin
         failures++;
         $display("FAIL chg_second_fill got iREN=%b iaddr=%h exp 1/00000024", iREN, iaddr);
      end
      model_fill(32'h24, 32'h2424_2424);
      access(32'h20, 0, 32'h0);   // line 8 hit
      access(32'h24, 0, 32'h0);   // line 9 hit
   endtask

   task automatic test_ren_drop();
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'h30; iwait = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         imemREN = 1'b0; imemaddr = $urandom;
         iwait = (k < 2); iload = (k == 2) ? 32'h3030_3030 : $urandom;
         #1;
         checks++;
         if (iREN !== 1'b1 || iaddr !== 32'h30) begin
            failures++;
            $display("FAIL drop_fill%0d got iREN=%b iaddr=%h exp 1/00000030", k, iREN, iaddr);
         end
      end
      model_fill(32'h30, 32'h3030_3030);
      @(negedge CLK);
      iwait = 1'b1;
      #1;
      checks++;
      if (iREN !== 1'b0 || ihit !== 1'b0 || imemload !== 32'h0) begin
         failures++;
         $display("FAIL drop_idle got iREN=%b ihit=%b load=%h exp 0/0/0", iREN, ihit, imemload);
      end
      access(32'h30, 0, 32'h0);
   endtask

   task automatic test_reset_mid_fill();
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'h50; iwait = 1'b1;
      @(negedge CLK);
      #1;
      checks++;
      if (iREN !== 1'b1) begin
         failures++;
         $display("FAIL rmf_in_fill got iREN=%b exp 1", iREN);
      end
      #2;
      nRST = 1'b0;
      #1;
      checks++;
      if (iREN !== 1'b0 || iaddr !== 32'h0) begin
         failures++;
         $display("FAIL rmf_async_drop got iREN=%b iaddr=%h exp 0/00000000", iREN, iaddr);
      end
      model_clear();
      imemREN = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      access(32'h50, 1, 32'h5050_5050);
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            @(negedge CLK);
            imemREN = 1'b0; imemaddr = $urandom; iwait = $urandom;
            #1;
            checks++;
            if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0) begin
               failures++;
               $display("FAIL rand_idle got ihit=%b load=%h iREN=%b exp 0/0/0",
                        ihit, imemload, iREN);
            end
         end else begin
            a = {$urandom_range(0, 3) == 0 ? 24'(($urandom)) : 24'h0,
                 2'($urandom), 4'($urandom), 2'($urandom)};
            access(a, $urandom_range(0, 3), $urandom);
         end
      end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_conflict();
      test_addr_change();
      test_ren_drop();
      test_reset_mid_fill();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
